instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/if_pkg.sv | 14 +
 rtl/fetch_fifo.sv | 56 +++++
 rtl/instr_fetch.sv | 108 ++++++++++
 3 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch unit.
package if_pkg;

    typedef enum logic [1:0] {
        StBoot = 2'd0,
        StRun  = 2'd1,
        StHalt = 2'd2
    } if_state_e;

    localparam logic [31:0] EBREAK_INST      = 32'h0010_0073;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int unsigned FIFO_W           = 64;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry {pc, inst} buffer between fetch and decode; entry 0 is always the head.
module fetch_fifo
    import if_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic              flush_i,
    input  logic [FIFO_W-1:0] din_i,
    output logic [FIFO_W-1:0] dout_o,
    output logic [1:0]        count_o
);

    logic [FIFO_W-1:0] e0_q, e0_d, e1_q, e1_d;
    logic [1:0]        cnt_q, cnt_d, level;

    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        cnt_d = cnt_q;
        level = cnt_q - {1'b0, pop_i};
        if (flush_i) begin
            cnt_d = 2'd0;
        end else begin
            if (pop_i) begin
                e0_d = e1_q;
            end
            // Push lands in the first free slot after the pop has shifted.
            if (push_i) begin
                if (level == 2'd0) begin
                    e0_d = din_i;
                end else begin
                    e1_d = din_i;
                end
            end
            cnt_d = level + {1'b0, push_i};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0_q  <= '0;
            e1_q  <= '0;
            cnt_q <= 2'd0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            cnt_q <= cnt_d;
        end
    end

    assign dout_o  = e0_q;
    assign count_o = cnt_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC sequencing, BOOT/RUN/HALT control and a 2-deep decode buffer.
// Optional performance counters are built when IF_PERF_CNT_EN is defined.
module instr_fetch
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [4:0]  addressIM,
    input  logic [31:0] inst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        halted
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);

    if_state_e         state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [1:0]        count;
    logic [FIFO_W-1:0] head;
    logic              pop, fetch;
    logic              unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign addressIM = pc_q[6:2];
    assign out_valid = (count != 2'd0);
    assign out_pc    = head[63:32];
    assign out_inst  = head[31:0];
    assign halted    = (state_q == StHalt);
    assign pop       = out_valid && out_ready;
    assign fetch     = (state_q == StRun) && !redirect_valid && ((count != 2'd2) || pop);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (redirect_valid) begin
            pc_d    = {redirect_pc[31:2], 2'b00};
            state_d = StRun;
        end else begin
            if (fetch) begin
                pc_d = pc_q + 32'd4;
            end
            case (state_q)
                StBoot:  state_d = StRun;
                StRun:   if (fetch && (inst == EBREAK_INST)) state_d = StHalt;
                StHalt:  state_d = StHalt;
                default: state_d = StBoot;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StBoot;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    fetch_fifo u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fetch),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .din_i   ({pc_q, inst}),
        .dout_o  (head),
        .count_o (count)
    );

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetched_q, fetched_d, stall_q, stall_d;

    always_comb begin
        fetched_d = fetched_q + {31'd0, fetch};
        stall_d   = stall_q;
        if ((state_q == StRun) && (count == 2'd2) && !pop) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetched_q <= '0;
            stall_q   <= '0;
        end else begin
            fetched_q <= fetched_d;
            stall_q   <= stall_d;
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_stall   = stall_q;
`endif

endmodule
